// File: rtl/rate_change_ctrl_pkg.sv
// Shared types and constants for the rate-change sequencer.
//   rc_state_t          : sequencer state encoding (also exported for debug)
//   CLEAR_PULSE_CYCLES  : length of the clear/clear_user pulse
//   DEF_SR_N_ADDR/M_ADDR: default settings-bus addresses for N and M
//   rate_ok()           : true when a requested rate lies in 1..max_v
package rate_change_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_GATE  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4,
        ST_WR_N  = 3'd5,
        ST_WR_M  = 3'd6,
        ST_DONE  = 3'd7
    } rc_state_t;

    localparam int         CLEAR_PULSE_CYCLES = 2;
    localparam logic [7:0] DEF_SR_N_ADDR      = 8'd0;
    localparam logic [7:0] DEF_SR_M_ADDR      = 8'd1;

    function automatic logic rate_ok(input logic [15:0] v, input int max_v);
        return (v != 16'd0) && (32'(v) <= 32'(max_v));
    endfunction

endpackage

// File: rtl/rate_change_ctrl_axis_pkt_gate.sv
// Packet-boundary gate for the AXI-stream control signals feeding the core.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   s_tvalid, s_tlast     : upstream beat qualifiers
//   m_tready              : downstream ready from the core
//   s_tready, m_tvalid    : gated handshake signals
//   close_req             : sequencer asks the gate to close
//   open_req              : sequencer reopens the gate
//   close_ack             : gate is closed or closes on this edge
module axis_pkt_gate (
    input  logic clk,
    input  logic reset_n,
    input  logic s_tvalid,
    input  logic s_tlast,
    input  logic m_tready,
    input  logic close_req,
    input  logic open_req,
    output logic s_tready,
    output logic m_tvalid,
    output logic close_ack
);

    logic open_q;
    logic in_pkt_q;
    logic beat;
    logic closing;

    assign s_tready = m_tready & open_q;
    assign m_tvalid = s_tvalid & open_q;
    assign beat     = s_tvalid & s_tready;

    // Closing is decided on the current beat: only between packets and only
    // in a cycle where nothing is accepted, so a packet is never split.
    assign closing   = close_req & open_q & ~in_pkt_q & ~beat;
    assign close_ack = closing | (close_req & ~open_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q   <= 1'b1;
            in_pkt_q <= 1'b0;
        end else begin
            if (open_req) begin
                open_q <= 1'b1;
            end else if (closing) begin
                open_q <= 1'b0;
            end
            if (beat) begin
                in_pkt_q <= ~s_tlast;
            end
        end
    end

endmodule

// File: rtl/rate_change_ctrl.sv
// Run-time reconfiguration sequencer for an axi_rate_change core.
// Accepts (N, M) requests, gates input at a packet boundary, waits for the
// core output to go quiet, pulses the clears, writes N and M over the
// settings bus and reopens the input.
// Optional build macro RATE_CHANGE_CTRL_SKIP_SAME_EN: a request equal to the
// active rate completes immediately without gating, clearing or writing.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   req_valid/req_ready/req_n/m : rate-request handshake
//   rsp_valid, rsp_error        : completion pulse and reject flag
//   s_tvalid/s_tlast/s_tready   : upstream stream control
//   m_tvalid/m_tready           : gated stream control to the core
//   o_tvalid, o_tready          : core output monitor
//   clear, clear_user           : core clears
//   set_stb/set_addr/set_data   : settings bus
//   cur_n, cur_m                : active rate
//   busy                        : sequencer not idle
//   warning_drain_timeout       : drain took too long (sticky)
//   state                       : current sequencer state (debug)
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits for ready.
module rate_change_ctrl
    import rate_change_ctrl_pkg::*;
#(
    parameter int         MAX_N         = 16,
    parameter int         MAX_M         = 16,
    parameter logic [7:0] SR_N_ADDR     = DEF_SR_N_ADDR,
    parameter logic [7:0] SR_M_ADDR     = DEF_SR_M_ADDR,
    parameter int         QUIET_CYCLES  = 32,
    parameter int         DRAIN_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_n,
    input  logic [15:0] req_m,
    output logic        rsp_valid,
    output logic        rsp_error,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic        m_tvalid,
    input  logic        m_tready,
    input  logic        o_tvalid,
    input  logic        o_tready,
    output logic        clear,
    output logic        clear_user,
    output logic        set_stb,
    output logic [7:0]  set_addr,
    output logic [31:0] set_data,
    output logic [15:0] cur_n,
    output logic [15:0] cur_m,
    output logic        busy,
    output logic        warning_drain_timeout,
    output rc_state_t   state
);

    rc_state_t   state_q, state_d;
    logic [15:0] n_q, m_q;
    logic [15:0] cur_n_q, cur_m_q;
    logic        err_q;
    logic [15:0] quiet_q;
    logic [31:0] tmo_q;
    logic [1:0]  clr_cnt_q;
    logic        warn_q;

    logic close_req, open_req, close_ack;
    logic out_xfer;
    logic bad_req;
    logic same_req;

    assign out_xfer = o_tvalid & o_tready;
    assign bad_req  = ~rate_ok(n_q, MAX_N) | ~rate_ok(m_q, MAX_M);

`ifdef RATE_CHANGE_CTRL_SKIP_SAME_EN
    assign same_req = (n_q == cur_n_q) && (m_q == cur_m_q);
`else
    assign same_req = 1'b0;
`endif

    axis_pkt_gate u_gate (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .m_tready  (m_tready),
        .close_req (close_req),
        .open_req  (open_req),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .close_ack (close_ack)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_error  = 1'b0;
        clear      = 1'b0;
        clear_user = 1'b0;
        set_stb    = 1'b0;
        set_addr   = 8'd0;
        set_data   = 32'd0;
        close_req  = 1'b0;
        open_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bad_req || same_req) state_d = ST_DONE;
                else                     state_d = ST_GATE;
            end
            ST_GATE: begin
                close_req = 1'b1;
                if (close_ack) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // quiet_q counts idle cycles since the last transfer.
                if (!out_xfer && quiet_q == 16'(QUIET_CYCLES - 1)) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clear      = 1'b1;
                clear_user = 1'b1;
                if (clr_cnt_q == 2'(CLEAR_PULSE_CYCLES - 1)) state_d = ST_WR_N;
            end
            ST_WR_N: begin
                set_stb  = 1'b1;
                set_addr = SR_N_ADDR;
                set_data = {16'd0, n_q};
                state_d  = ST_WR_M;
            end
            ST_WR_M: begin
                set_stb  = 1'b1;
                set_addr = SR_M_ADDR;
                set_data = {16'd0, m_q};
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                open_req  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            n_q       <= 16'd0;
            m_q       <= 16'd0;
            cur_n_q   <= 16'd1;
            cur_m_q   <= 16'd1;
            err_q     <= 1'b0;
            quiet_q   <= 16'd0;
            tmo_q     <= 32'd0;
            clr_cnt_q <= 2'd0;
            warn_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && req_valid) begin
                n_q    <= req_n;
                m_q    <= req_m;
                warn_q <= 1'b0;
            end

            if (state_q == ST_CHECK) err_q <= bad_req;

            if (state_q != ST_DRAIN || out_xfer) quiet_q <= 16'd0;
            else                                 quiet_q <= quiet_q + 16'd1;

            // Timeout only warns; the drain still has to finish on its own.
            if (state_q != ST_DRAIN) begin
                tmo_q <= 32'd0;
            end else if (tmo_q < 32'(DRAIN_TIMEOUT)) begin
                tmo_q <= tmo_q + 32'd1;
                if (tmo_q == 32'(DRAIN_TIMEOUT - 1)) warn_q <= 1'b1;
            end

            if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 2'd1;
            else                     clr_cnt_q <= 2'd0;

            if (state_q == ST_WR_M) begin
                cur_n_q <= n_q;
                cur_m_q <= m_q;
            end
        end
    end

    assign cur_n                 = cur_n_q;
    assign cur_m                 = cur_m_q;
    assign busy                  = (state_q != ST_IDLE);
    assign warning_drain_timeout = warn_q;
    assign state                 = state_q;

endmodule

// File: tb/tb_rate_change_ctrl.sv
module tb_rate_change_ctrl;
    import rate_change_ctrl_pkg::*;

    localparam int QUIET = 32;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [15:0] req_n, req_m;
    logic        rsp_valid, rsp_error;
    logic        s_tvalid, s_tlast, s_tready;
    logic        m_tvalid, m_tready;
    logic        o_tvalid, o_tready;
    logic        clear, clear_user;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] cur_n, cur_m;
    logic        busy, warning_drain_timeout;
    rc_state_t   dut_state;

    rate_change_ctrl #(
        .MAX_N(16), .MAX_M(16), .SR_N_ADDR(8'd0), .SR_M_ADDR(8'd1),
        .QUIET_CYCLES(QUIET), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_m(req_m),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .clear(clear), .clear_user(clear_user),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .cur_n(cur_n), .cur_m(cur_m), .busy(busy),
        .warning_drain_timeout(warning_drain_timeout), .state(dut_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    logic [0:0]  exp_q[$];   // expected rsp_error per response
    logic [39:0] set_q[$];   // expected {set_addr, set_data}
    int n_tests = 0;
    int n_fail  = 0;

    int hs_cyc = -1000, clear_cnt = 0, clear_first = -1, drain_cyc = -1;
    int warn_cyc = -1, last_xfer = -1, rsp_cnt = 0, rsp_cyc = -1;
    rc_state_t st_trace[8];
    logic tb_in_pkt = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (req_valid && req_ready) begin
                hs_cyc = cyc; clear_cnt = 0; clear_first = -1; drain_cyc = -1; warn_cyc = -1;
            end else if (cyc - hs_cyc >= 0 && cyc - hs_cyc < 8) begin
                st_trace[cyc - hs_cyc] = dut_state;
            end
            if (dut_state == ST_DRAIN && drain_cyc < 0) drain_cyc = cyc;
            if (warning_drain_timeout && warn_cyc < 0) warn_cyc = cyc;
            if (o_tvalid && o_tready) last_xfer = cyc;
            if (s_tvalid && s_tready) tb_in_pkt = ~s_tlast;
            if (clear) begin
                clear_cnt++;
                if (clear_first < 0) clear_first = cyc;
                check("clear_in_pkt", tb_in_pkt, 0);
                check("clear_user", clear_user, clear);
            end
            if (set_stb) begin
                if (set_q.size() == 0) check("set_unexpected", set_stb, 0);
                else check("set_write", {set_addr, set_data}, set_q.pop_front());
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
                else check("rsp_error", rsp_error, exp_q.pop_front());
                rsp_cnt++;
                rsp_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [15:0] n, input logic [15:0] m);
        logic ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_n = n; req_m = m;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_accepted", ok, 1);
    endtask

    task automatic wait_rsp(input int start, input int budget, input string tag);
        int c = 0;
        while (rsp_cnt == start && c < budget) begin
            @(posedge clk); c++;
        end
        #1;
        check(tag, rsp_cnt != start, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int start, beats, early;
        logic got, saw, req_done, found;
        rc_state_t st_at_warn;
        logic [15:0] bad_tab[3][2];
        bad_tab[0][0] = 16'd0;  bad_tab[0][1] = 16'd2;
        bad_tab[1][0] = 16'd17; bad_tab[1][1] = 16'd1;
        bad_tab[2][0] = 16'd3;  bad_tab[2][1] = 16'd0;

        reset_n = 1'b0; req_valid = 1'b0; req_n = '0; req_m = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        o_tvalid = 1'b0; o_tready = 1'b1;
        #12;
        // reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_clear", clear, 0);
        check("rst_set_stb", set_stb, 0);
        check("rst_set_addr", set_addr, 0);
        check("rst_set_data", set_data, 0);
        check("rst_cur_n", cur_n, 1);
        check("rst_cur_m", cur_m, 1);
        check("rst_busy", busy, 0);
        check("rst_warn", warning_drain_timeout, 0);
        check("rst_gate_open", s_tready, 1);
        @(posedge clk); #1 reset_n = 1'b1;

        // (4,3) with idle input: full sequence and timing
        exp_q.push_back(1'b0);
        set_q.push_back({8'd0, 32'd4});
        set_q.push_back({8'd1, 32'd3});
        start = rsp_cnt;
        do_req(16'd4, 16'd3);
        wait_rsp(start, 100, "rsp_4_3");
        check("t1_check_state", st_trace[1], ST_CHECK);
        check("t1_gate_state", st_trace[2], ST_GATE);
        check("t1_drain_state", st_trace[3], ST_DRAIN);
        check("t1_clear_time", clear_first - hs_cyc, 3 + QUIET);
        check("t1_clear_len", clear_cnt, 2);
        check("t1_rsp_time", rsp_cyc - hs_cyc, 3 + QUIET + 4);
        check("t1_cur_n", cur_n, 4);
        check("t1_cur_m", cur_m, 3);

        // (5,5) with output beats every 20 cycles: drain timeout warning
        exp_q.push_back(1'b0);
        set_q.push_back({8'd0, 32'd5});
        set_q.push_back({8'd1, 32'd5});
        start = rsp_cnt;
        do_req(16'd5, 16'd5);
        got = 1'b0; st_at_warn = ST_IDLE;
        for (int c = 0; c < 400; c++) begin
            o_tvalid = (c % 20 == 0);
            @(negedge clk);
            if (warning_drain_timeout) begin got = 1'b1; st_at_warn = dut_state; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1 o_tvalid = 1'b0;
        check("t2_warn_set", got, 1);
        check("t2_warn_time", warn_cyc - drain_cyc, TMO);
        check("t2_still_drain", st_at_warn, ST_DRAIN);
        wait_rsp(start, 200, "rsp_5_5");
        check("t2_clear_after_quiet", clear_first - last_xfer, QUIET + 1);
        check("t2_warn_sticky", warning_drain_timeout, 1);
        check("t2_cur_n", cur_n, 5);

        // illegal requests: error at H+2, no clear, no writes, rate kept
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1'b1);
            start = rsp_cnt;
            do_req(bad_tab[i][0], bad_tab[i][1]);
            wait_rsp(start, 20, "rsp_bad");
            check("bad_rsp_time", rsp_cyc - hs_cyc, 2);
            check("bad_no_clear", clear_cnt, 0);
            check("bad_cur_n", cur_n, 5);
            check("bad_cur_m", cur_m, 5);
            check("bad_warn_cleared", warning_drain_timeout, 0);
        end

        // request at beat 5 of a 16-beat packet
        exp_q.push_back(1'b0);
        set_q.push_back({8'd0, 32'd6});
        set_q.push_back({8'd1, 32'd2});
        start = rsp_cnt; beats = 0; req_done = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 100 && beats < 16; c++) begin
            s_tvalid = 1'b1; s_tlast = (beats == 15);
            req_valid = (beats >= 4) && !req_done; req_n = 16'd6; req_m = 16'd2;
            @(negedge clk);
            if (req_valid && req_ready) req_done = 1'b1;
            if (s_tvalid && s_tready) beats++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        check("t3_req_taken", req_done, 1);
        check("t3_pkt_beats", beats, 16);
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tlast = 1'b1;
        early = 0; saw = 1'b0; got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
            if (s_tready) begin
                if (!saw) early++;
                else got = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("t3_blocked_beats", early, 0);
        check("t3_reopened", got, 1);
        check("t3_rsp_seen", rsp_cnt - start, 1);
        check("t3_cur_n", cur_n, 6);
        check("t3_cur_m", cur_m, 2);

        // asynchronous reset during WR_N
        exp_q.push_back(1'b0);
        set_q.push_back({8'd0, 32'd7});
        do_req(16'd7, 16'd7);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dut_state == ST_WR_N) begin found = 1'b1; break; end
        end
        check("t4_reached_wr_n", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t4_req_ready", req_ready, 1);
        check("t4_rsp_valid", rsp_valid, 0);
        check("t4_set_stb", set_stb, 0);
        check("t4_set_data", set_data, 0);
        check("t4_clear", clear, 0);
        check("t4_cur_n", cur_n, 1);
        check("t4_cur_m", cur_m, 1);
        check("t4_busy", busy, 0);
        check("t4_state", dut_state, ST_IDLE);
        check("t4_gate_open", s_tready, 1);
        exp_q.delete();
        start = rsp_cnt;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1; tb_in_pkt = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t4_no_rsp", rsp_cnt, start);

        // (1,1) right after reset: matches the reset rate
        exp_q.push_back(1'b0);
        start = rsp_cnt;
`ifdef RATE_CHANGE_CTRL_SKIP_SAME_EN
        do_req(16'd1, 16'd1);
        wait_rsp(start, 20, "rsp_same");
        check("t5_rsp_time", rsp_cyc - hs_cyc, 2);
        check("t5_no_clear", clear_cnt, 0);
`else
        set_q.push_back({8'd0, 32'd1});
        set_q.push_back({8'd1, 32'd1});
        do_req(16'd1, 16'd1);
        wait_rsp(start, 100, "rsp_same");
        check("t5_rsp_time", rsp_cyc - hs_cyc, 3 + QUIET + 4);
        check("t5_clear_len", clear_cnt, 2);
`endif
        check("t5_cur_n", cur_n, 1);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        check("set_q_empty", set_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_change_ctrl.md
# rate_change_ctrl

Sequencer that reconfigures a downstream `axi_rate_change` instance at run time without corrupting packets. It accepts rate requests (N, M) over a valid/ready handshake and gates new input packets at a packet boundary. It waits for the datapath to drain, pulses `clear`/`clear_user`, then writes N and M over the settings bus before reopening the input. It sits between the block's input AXI-stream and the rate-change core, next to the settings-bus master.

## Interface
- `MAX_N`, 16: largest legal N.
- `MAX_M`, 16: largest legal M.
- `SR_N_ADDR`, 0: settings address for N.
- `SR_M_ADDR`, 1: settings address for M.
- `QUIET_CYCLES`, 32: consecutive idle output cycles that define "drained".
- `DRAIN_TIMEOUT`, 65535: DRAIN cycles before `warning_drain_timeout` is raised.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: rate-request handshake.
- `req_n` in 16, `req_m` in 16: requested rate.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_error` out 1: qualifies `rsp_valid`; set when the request was rejected.
- `s_tvalid` in 1, `s_tlast` in 1, `s_tready` out 1: upstream stream control. Data bypasses this block.
- `m_tvalid` out 1, `m_tready` in 1: gated stream control to the core.
- `o_tvalid` in 1, `o_tready` in 1: core output monitor.
- `clear` out 1, `clear_user` out 1: core clears.
- `set_stb` out 1, `set_addr` out 8, `set_data` out 32: settings bus.
- `cur_n` out 16, `cur_m` out 16: active rate.
- `busy` out 1: high in any state other than IDLE.
- `warning_drain_timeout` out 1: sticky until the next request is accepted.

## Operation
- Reset values:
  - `req_ready=1`, `rsp_valid=0`, `rsp_error=0`.
  - `clear=0`, `clear_user=0`, `set_stb=0`, `set_addr=0`, `set_data=0`.
  - `cur_n=1`, `cur_m=1`, `busy=0`, warning=0.
  - Gate open; the in-packet flag is clear.
- Gate:
  - `m_tvalid = s_tvalid & open`, `s_tready = m_tready & open`.
  - `in_pkt` sets on an accepted beat with `!s_tlast` and clears on an accepted beat with `s_tlast`.
  - `open` drops only when `!in_pkt` and no beat is accepted in the current cycle. A packet is never split.
- States: IDLE → CHECK → GATE → DRAIN → CLEAR → WR_N → WR_M → DONE → IDLE.
- IDLE: `req_ready=1`. On handshake, latch N and M, drop `req_ready`, go to CHECK.
- CHECK (1 cycle):
  - N or M equal to 0, N>MAX_N, or M>MAX_M → DONE with error.
  - Otherwise → GATE.
- GATE: wait until the gate closes, then go to DRAIN with the quiet counter reset.
- DRAIN:
  - The quiet counter increments on each cycle without `o_tvalid&o_tready` and resets to 0 on each transfer.
  - When the counter reaches QUIET_CYCLES-1 → CLEAR.
  - A separate timeout counter saturates at DRAIN_TIMEOUT and sets the warning; the FSM stays in DRAIN.
- CLEAR: `clear` and `clear_user` high for exactly 2 cycles, then → WR_N.
- WR_N: one cycle with `set_stb=1`, `set_addr=SR_N_ADDR`, `set_data={16'd0,N}`.
- WR_M: same form, with SR_M_ADDR and M. Update `cur_n` and `cur_m` in the same cycle.
- DONE:
  - `rsp_valid=1` for one cycle; `rsp_error` as determined in CHECK.
  - Reopen the gate; return to IDLE.
  - An error request leaves the gate, `cur_*` and the core untouched.
- `set_stb`, `set_addr` and `set_data` return to 0 outside WR_N and WR_M.
- An asynchronous reset in any state immediately restores the reset values. An in-flight request is discarded with no response.

## Timing
- Valid request with the gate already closable and the output idle, measured from the handshake cycle H:
  - CHECK at H+1, GATE at H+2, DRAIN at H+3.
  - CLEAR starts at H+3+QUIET_CYCLES.
  - WR_N at CLEAR+2, WR_M at CLEAR+3, `rsp_valid` at CLEAR+4.
- Error request: `rsp_valid` at H+2.
- Gate-close decision is combinational on the current beat. The gate register updates on the next edge.
- Each output beat seen during DRAIN extends the drain by at least QUIET_CYCLES.
- `req_valid` held high in DONE is not accepted until the IDLE cycle after DONE.

## Configuration
- `RATE_CHANGE_CTRL_SKIP_SAME_EN` defined:
  - A valid request whose N and M equal `cur_n`/`cur_m` goes CHECK → DONE with `rsp_error=0`.
  - No gating, clear or settings write occurs.
- Not defined: every valid request runs the full sequence.

## Structure
- Package `rate_change_ctrl_pkg`: state enum `rc_state_t`, CLEAR_PULSE_CYCLES=2, default SR addresses.
- Sub-module `axis_pkt_gate`: in-packet tracking, close request/ack and gating. The FSM, counters and settings driver stay in the top level.

## Test plan
- Request (4,3) with idle input → CHECK, then `clear` for 2 cycles, then writes (0,4) and (1,3), then `rsp_valid=1`, `rsp_error=0`, `cur=4/3`, and timing matches H+3+QUIET_CYCLES.
- Request issued mid-packet (beat 5 of 16) → all 16 beats pass the gate and no further beat is accepted until DONE. `clear` never asserts while `in_pkt=1`.
- Requests (0,2), (17,1) and (3,0) → each gives `rsp_error=1` at H+2, with no `clear`, no `set_stb` and `cur_*` unchanged.
- Output beats every 20 cycles with QUIET_CYCLES=32 → FSM stays in DRAIN. Set DRAIN_TIMEOUT=100 → warning sets at 100 cycles, stops output, CLEAR follows 32 quiet cycles later, and the warning clears on the next accepted request.
- Assert `reset_n` low during WR_N → all outputs reach reset values asynchronously. No response is issued and the gate reopens.
- With `RATE_CHANGE_CTRL_SKIP_SAME_EN`: request (1,1) after reset → `rsp_valid` at H+2 with no clear. Without the macro, the full sequence runs.
